cpu_mc: RTL and testbench
=========================

# cpu_mc

Multi-cycle, parametrised accumulator CPU that succeeds the single-cycle `cpu`. It has one unified instruction/data memory reached over a req/ack handshake that tolerates wait states. A state machine sequences fetch, decode and execute, and a sticky HALT state stops execution. Data width and address width are generic, and debug outputs expose the architectural state.

## Interface
- `DATA_W`, default 8: accumulator and memory word width. Must satisfy `DATA_W >= ADDR_W + 3`.
- `ADDR_W`, default 5: memory address width, which is also the PC and operand width.

- `clk_i` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `mem_req_o` output 1: memory request, held until acknowledged.
- `mem_we_o` output 1: 1 means write; valid while `mem_req_o` is high.
- `mem_addr_o` output ADDR_W: request address.
- `mem_wdata_o` output DATA_W: write data (the accumulator).
- `mem_rdata_i` input DATA_W: read data, sampled in the ack cycle.
- `mem_ack_i` input 1: completes a request in the cycle where `mem_req_o && mem_ack_i`.
- `halted_o` output 1: high while in HALT.
- `acc_o` output DATA_W: accumulator.
- `pc_o` output ADDR_W: program counter.
- `ir_o` output DATA_W: instruction register.
- `flag_z_o` output 1: zero flag.
- `flag_c_o` output 1: carry/borrow flag.
- `state_o` output 2: FETCH=0, DECODE=1, EXEC=2, HALT=3.

## Operation
- Instruction encoding: opcode = `ir[DATA_W-1:DATA_W-3]`, operand = `ir[ADDR_W-1:0]`. Bits between them are ignored.
- Opcodes:
  - 000 LD: acc = M[op].
  - 001 ST: M[op] = acc.
  - 010 ADD: acc = acc + M[op].
  - 011 SUB: acc = acc - M[op].
  - 100 JMP: pc = op.
  - 101 JZ: jump if Z.
  - 110 JC: jump if C.
  - 111 HLT.
- FETCH: req read at `pc`. On ack: `ir <= mem_rdata_i`, `pc <= pc+1` (modulo 2^ADDR_W), go to DECODE.
- DECODE, no memory access, always one cycle:
  - JMP: `pc <= op`, go to FETCH.
  - JZ/JC: `pc <= op` if the flag is set, else `pc` unchanged; go to FETCH.
  - HLT: go to HALT.
  - LD/ST/ADD/SUB: go to EXEC.
- EXEC: req at `op`, with `mem_we_o` = (opcode==ST). On ack, go to FETCH and update:
  - LD: acc = rdata; Z = (rdata==0); C unchanged.
  - ADD: {C, acc} = acc + rdata (DATA_W+1-bit sum); Z = (new acc==0).
  - SUB: acc = acc - rdata modulo 2^DATA_W; C = (acc < rdata), i.e. borrow; Z = (new acc==0).
  - ST: write acc; flags and acc unchanged.
- HALT: no requests. Stays in HALT until `reset`.
- Flags are modified only as listed above. Jumps never change flags.

## Timing
- Reset values, applied on a clock edge with `reset`=1:
  - state = FETCH.
  - pc, acc, ir = 0.
  - Z, C = 0.
  - `halted_o` = 0.
- `mem_req_o` is forced to 0 in any cycle where `reset`=1. Otherwise `mem_req_o` = (state==FETCH or EXEC).
- `mem_addr_o`, `mem_we_o` and `mem_wdata_o` stay stable for as long as `mem_req_o` is high and unacknowledged.
- `mem_ack_i` is ignored while `mem_req_o`=0.
- Ack may arrive in the same cycle as the request (zero-wait) or any number of cycles later. Without ack, the state and all registers hold.
- Zero-wait latency:
  - JMP/JZ/JC/HLT take 2 cycles.
  - LD/ST/ADD/SUB take 3 cycles.
  - Each wait cycle adds 1.
- Reset during a pending request abandons the request. The next cycle after reset release is a FETCH at address 0.
- PC wrap: fetching at address 2^ADDR_W-1 leaves pc = 0.
- Debug outputs are register values. They change on the clock edge that performs the update.

## Test plan
- Reset with default parameters: all outputs at reset values. `mem_req_o`=1, `mem_addr_o`=0, `mem_we_o`=0 in the first cycle after release.
- Program "LD 10; ADD 11; ST 12; HLT", zero-wait, M[10]=0xF0, M[11]=0x20.
  - Result: acc=0x10, C=1, Z=0, M[12]=0x10.
  - `halted_o` rises on the 12th cycle after release and stays high; no further `mem_req_o`.
- SUB cases:
  - 0x05-0x07: acc=0xFE, C=1, Z=0.
  - 0x07-0x07: acc=0x00, C=0, Z=1.
  - Then JZ 20: pc=20. A following JC with C=0 is not taken (pc = JC address + 1).
- Wait states: ack delayed 3 cycles on every request.
  - `mem_req_o`/addr/we/wdata held stable throughout.
  - Final results identical to the zero-wait program run.
  - Total cycle count increases by 3 per access.
- Wrap and reset:
  - JMP 31 to a LD at address 31: the next fetch address is 0.
  - Reset asserted in EXEC with no ack: the request drops and the first post-reset fetch address is 0.
- Second instance with DATA_W=16, ADDR_W=8: ADD 0xFFFF+0x0001 gives acc=0x0000, C=1, Z=1.

Source files
------------

// File: rtl/cpu_mc.sv
// Multi-cycle accumulator CPU with a unified req/ack memory port.
// FETCH -> DECODE -> (EXEC) sequencing; HLT parks the core until reset.
module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              halted_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ir_o,
  output logic              flag_z_o,
  output logic              flag_c_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_ST  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic              z_reg, z_next;
  logic              c_reg, c_next;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              ack;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign opcode  = ir_reg[DATA_W-1 -: 3];
  assign operand = ir_reg[ADDR_W-1:0];

  // Request is combinational from the state register so that a reset cycle
  // never issues a request, even while the state register still holds EXEC.
  assign mem_req_o   = !reset && (state_reg == FETCH || state_reg == EXEC);
  assign mem_we_o    = (state_reg == EXEC) && (opcode == OP_ST);
  assign mem_addr_o  = (state_reg == FETCH) ? pc_reg : operand;
  assign mem_wdata_o = acc_reg;
  assign ack         = mem_req_o && mem_ack_i;

  // The top bit of the widened difference is the borrow (acc < rdata).
  assign sum  = {1'b0, acc_reg} + {1'b0, mem_rdata_i};
  assign diff = {1'b0, acc_reg} - {1'b0, mem_rdata_i};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    acc_next   = acc_reg;
    ir_next    = ir_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    case (state_reg)
      FETCH: begin
        if (ack) begin
          ir_next    = mem_rdata_i;
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = FETCH;
        case (opcode)
          OP_JMP: pc_next = operand;
          OP_JZ:  if (z_reg) pc_next = operand;
          OP_JC:  if (c_reg) pc_next = operand;
          OP_HLT: state_next = HALT;
          default: state_next = EXEC;
        endcase
      end
      EXEC: begin
        if (ack) begin
          state_next = FETCH;
          case (opcode)
            OP_LD: begin
              acc_next = mem_rdata_i;
              z_next   = (mem_rdata_i == '0);
            end
            OP_ADD: begin
              acc_next = sum[DATA_W-1:0];
              c_next   = sum[DATA_W];
              z_next   = (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              acc_next = diff[DATA_W-1:0];
              c_next   = diff[DATA_W];
              z_next   = (diff[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      acc_reg   <= '0;
      ir_reg    <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      acc_reg   <= acc_next;
      ir_reg    <= ir_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
    end
  end

  assign halted_o = (state_reg == HALT);
  assign acc_o    = acc_reg;
  assign pc_o     = pc_reg;
  assign ir_o     = ir_reg;
  assign flag_z_o = z_reg;
  assign flag_c_o = c_reg;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: default 8/5 instance with a wait-state memory
// model, plus a 16/8 instance for the wide ADD carry case.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req, we, ack, halted, fz, fc;
  logic [4:0]  addr, pc;
  logic [7:0]  wdata, rdata, acc, ir;
  logic [1:0]  state;

  logic        reset2 = 1'b1;
  logic        req2, we2, ack2, halted2, fz2, fc2;
  logic [7:0]  addr2, pc2;
  logic [15:0] wdata2, rdata2, acc2, ir2;
  logic [1:0]  state2;

  logic [7:0]  mem   [32];
  logic [7:0]  prog  [32];
  logic [15:0] mem2  [256];
  logic [15:0] prog2 [256];
  logic        load = 1'b0;
  logic        ack_en = 1'b1;
  int          delay = 0;
  int          wait_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mc dut (
    .clk_i(clk), .reset(reset),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_rdata_i(rdata), .mem_ack_i(ack),
    .halted_o(halted), .acc_o(acc), .pc_o(pc), .ir_o(ir),
    .flag_z_o(fz), .flag_c_o(fc), .state_o(state)
  );

  cpu_mc #(.DATA_W(16), .ADDR_W(8)) dut2 (
    .clk_i(clk), .reset(reset2),
    .mem_req_o(req2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
    .mem_rdata_i(rdata2), .mem_ack_i(ack2),
    .halted_o(halted2), .acc_o(acc2), .pc_o(pc2), .ir_o(ir2),
    .flag_z_o(fz2), .flag_c_o(fc2), .state_o(state2)
  );

  assign rdata  = mem[addr];
  assign ack    = req && ack_en && (wait_cnt >= delay);
  assign rdata2 = mem2[addr2];
  assign ack2   = req2;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= prog[i];
      for (int i = 0; i < 256; i++) mem2[i] <= prog2[i];
    end else begin
      if (req && we && ack) mem[addr] <= wdata;
      if (req2 && we2 && ack2) mem2[addr2] <= wdata2;
    end
    if (reset || !req || ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  // Hold reset, copy the program image into memory, then release.
  task automatic load_and_release();
    reset = 1'b1;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
  endtask

  task automatic load_program_main();
    clear_prog();
    prog[0]  = 8'h0A;  // LD 10
    prog[1]  = 8'h4B;  // ADD 11
    prog[2]  = 8'h2C;  // ST 12
    prog[3]  = 8'hE0;  // HLT
    prog[10] = 8'hF0;
    prog[11] = 8'h20;
  endtask

  initial begin
    logic       pend;
    logic [4:0] paddr;
    logic       pwe;
    logic [7:0] pwdata;

    for (int i = 0; i < 256; i++) prog2[i] = 16'h0000;
    prog2[0]     = 16'h0010;  // LD 0x10
    prog2[1]     = 16'h4011;  // ADD 0x11
    prog2[2]     = 16'hE000;  // HLT
    prog2[8'h10] = 16'hFFFF;
    prog2[8'h11] = 16'h0001;

    // Reset values and first request after release.
    load_program_main();
    load = 1'b1;
    tick(2);
    load = 1'b0;
    tick(1);
    check("rst_state", state, 2'd0);
    check("rst_pc", pc, 5'd0);
    check("rst_acc", acc, 8'h00);
    check("rst_ir", ir, 8'h00);
    check("rst_z", fz, 1'b0);
    check("rst_c", fc, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_req", req, 1'b0);
    reset = 1'b0;
    #1;
    check("rel_req", req, 1'b1);
    check("rel_addr", addr, 5'd0);
    check("rel_we", we, 1'b0);

    // Zero-wait main program: halted first seen in cycle 12.
    tick(10);
    check("main_halt_c11", halted, 1'b0);
    tick(1);
    check("main_halt_c12", halted, 1'b1);
    check("main_acc", acc, 8'h10);
    check("main_c", fc, 1'b1);
    check("main_z", fz, 1'b0);
    check("main_m12", mem[12], 8'h10);
    check("main_pc", pc, 5'd4);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("halt_no_req", req, 1'b0);
      check("halt_sticky", halted, 1'b1);
    end

    // SUB / JZ / JC sequence.
    clear_prog();
    prog[0]  = 8'h10;  // LD 16
    prog[1]  = 8'h71;  // SUB 17
    prog[2]  = 8'h12;  // LD 18
    prog[3]  = 8'h71;  // SUB 17
    prog[4]  = 8'hB4;  // JZ 20
    prog[20] = 8'hD9;  // JC 25
    prog[21] = 8'hE0;  // HLT
    prog[16] = 8'h05;
    prog[17] = 8'h07;
    prog[18] = 8'h07;
    load_and_release();
    tick(6);
    check("sub1_acc", acc, 8'hFE);
    check("sub1_c", fc, 1'b1);
    check("sub1_z", fz, 1'b0);
    tick(6);
    check("sub2_acc", acc, 8'h00);
    check("sub2_c", fc, 1'b0);
    check("sub2_z", fz, 1'b1);
    tick(2);
    check("jz_pc", pc, 5'd20);
    tick(2);
    check("jc_pc", pc, 5'd21);
    check("jc_z_kept", fz, 1'b1);
    tick(2);
    check("sub_halt", halted, 1'b1);

    // Main program with 3 wait cycles per access: 7 accesses, halt in cycle 33.
    load_program_main();
    delay = 3;
    load_and_release();
    pend = 1'b0;
    paddr = '0;
    pwe = 1'b0;
    pwdata = '0;
    for (int k = 1; k <= 32; k++) begin
      if (pend) begin
        check("ws_req_held", req, 1'b1);
        check("ws_addr_held", addr, paddr);
        check("ws_we_held", we, pwe);
        check("ws_wdata_held", wdata, pwdata);
      end
      if (k == 32) check("ws_halt_c32", halted, 1'b0);
      pend = req && !ack;
      paddr = addr;
      pwe = we;
      pwdata = wdata;
      tick(1);
      #1;
    end
    check("ws_halt_c33", halted, 1'b1);
    check("ws_acc", acc, 8'h10);
    check("ws_c", fc, 1'b1);
    check("ws_z", fz, 1'b0);
    check("ws_m12", mem[12], 8'h10);
    delay = 0;

    // PC wrap via JMP 31, then reset while a load is stalled in EXEC.
    clear_prog();
    prog[0]  = 8'h9F;  // JMP 31
    prog[31] = 8'h05;  // LD 5
    prog[5]  = 8'h33;
    load_and_release();
    tick(3);
    check("wrap_pc", pc, 5'd0);
    tick(2);
    check("wrap_fetch_req", req, 1'b1);
    check("wrap_fetch_addr", addr, 5'd0);
    check("wrap_acc", acc, 8'h33);
    tick(4);
    ack_en = 1'b0;
    #1;
    check("stall_state", state, 2'd2);
    check("stall_addr", addr, 5'd5);
    tick(2);
    check("stall_hold_state", state, 2'd2);
    check("stall_hold_req", req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_exec_req", req, 1'b0);
    tick(1);
    reset = 1'b0;
    ack_en = 1'b1;
    #1;
    check("post_rst_state", state, 2'd0);
    check("post_rst_req", req, 1'b1);
    check("post_rst_addr", addr, 5'd0);
    check("post_rst_acc", acc, 8'h00);

    // Wide instance: 0xFFFF + 0x0001.
    reset2 = 1'b0;
    #1;
    tick(6);
    check("w16_acc", acc2, 16'h0000);
    check("w16_c", fc2, 1'b1);
    check("w16_z", fz2, 1'b1);
    tick(2);
    check("w16_halt", halted2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
